// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
package cla_pkg;

    // Width of one lookahead group inside a chunk.
    localparam int GROUP_W = 4;

    // Number of pipeline stages: one CHUNK-bit slice resolved per stage.
    function automatic int calc_stages(input int w, input int chunk);
        return w / chunk;
    endfunction

    // Control part of a stage record. The operand words and the partial sum
    // word travel alongside it in parallel arrays, because their width
    // depends on the W parameter of the instantiating module.
    //   carry : carry out of the last chunk resolved (carry-in of the next)
    //   gacc  : accumulated group generate of all chunks resolved so far
    //   pacc  : accumulated group propagate of all chunks resolved so far
    //   cmsb  : carry into the top bit of the last chunk resolved
    typedef struct packed {
        logic valid;
        logic carry;
        logic gacc;
        logic pacc;
        logic cmsb;
    } stage_ctrl_t;

endpackage

// File: rtl/cla_chunk.sv
// Combinational CHUNK-bit carry-lookahead slice built from 4-bit lookahead
// groups, with the group G/P terms folded into one chunk-level G/P pair.
module cla_chunk
    import cla_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             g_o,
    output logic             p_o,
    output logic             c_msb_o,
    output logic             cout_o
);

    localparam int NG = CHUNK / GROUP_W;

    logic [CHUNK-1:0] gen_s;
    logic [CHUNK-1:0] prop_s;
    logic [CHUNK:0]   carry_s;
    logic [NG-1:0]    grp_g_s;
    logic [NG-1:0]    grp_p_s;
    logic             chunk_g_s;
    logic             chunk_p_s;

    assign gen_s  = a_i & b_i;
    assign prop_s = a_i ^ b_i;

    // Per-group 4-bit lookahead carries; groups are chained on their G/P pair.
    always_comb begin
        logic [GROUP_W-1:0] g4;
        logic [GROUP_W-1:0] p4;
        logic               c0;
        carry_s    = '0;
        grp_g_s    = '0;
        grp_p_s    = '0;
        g4         = '0;
        p4         = '0;
        c0         = 1'b0;
        carry_s[0] = cin_i;
        for (int n = 0; n < NG; n++) begin
            g4 = gen_s[n*GROUP_W +: GROUP_W];
            p4 = prop_s[n*GROUP_W +: GROUP_W];
            c0 = carry_s[n*GROUP_W];
            carry_s[n*GROUP_W+1] = g4[0] | (p4[0] & c0);
            carry_s[n*GROUP_W+2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c0);
            carry_s[n*GROUP_W+3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                                 | (p4[2] & p4[1] & p4[0] & c0);
            grp_g_s[n] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                       | (p4[3] & p4[2] & p4[1] & g4[0]);
            grp_p_s[n] = &p4;
            carry_s[n*GROUP_W+4] = grp_g_s[n] | (grp_p_s[n] & c0);
        end
    end

    // Fold group G/P into the chunk G/P pair; independent of the carry-in.
    always_comb begin
        chunk_g_s = 1'b0;
        chunk_p_s = 1'b1;
        for (int n = 0; n < NG; n++) begin
            chunk_g_s = grp_g_s[n] | (grp_p_s[n] & chunk_g_s);
            chunk_p_s = chunk_p_s & grp_p_s[n];
        end
    end

    assign s_o     = prop_s ^ carry_s[CHUNK-1:0];
    assign g_o     = chunk_g_s;
    assign p_o     = chunk_p_s;
    assign c_msb_o = carry_s[CHUNK-1];
    assign cout_o  = carry_s[CHUNK];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK-bit slice per stage,
// carry and accumulated G/P rippled through registers between stages.
// Operand words are skewed forward, finished sum chunks deskewed forward.
// W must be a multiple of CHUNK, CHUNK a multiple of 4.
// Optional build macro CLA_SAT_EN: saturate the sum on signed overflow
// instead of wrapping modulo 2^W.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         g_out,
    output logic         p_out
);

    localparam int STAGES = calc_stages(W, CHUNK);
    localparam int LAST   = STAGES - 1;

    // Stage k registers hold the record after chunk k has been resolved.
    stage_ctrl_t  ctrl_q [STAGES];
    stage_ctrl_t  ctrl_d [STAGES];
    logic [W-1:0] a_q    [STAGES];
    logic [W-1:0] a_d    [STAGES];
    logic [W-1:0] b_q    [STAGES];
    logic [W-1:0] b_d    [STAGES];
    logic [W-1:0] sum_q  [STAGES];
    logic [W-1:0] sum_d  [STAGES];

    // Result registers, loaded only when a valid record leaves the last stage.
    logic [W-1:0] res_sum_q;
    logic         res_cout_q;
    logic         res_ovf_q;
    logic         res_g_q;
    logic         res_p_q;

    logic         en_s;
    logic         ovf_s;
    logic [W-1:0] sum_fin_s;

    // The whole pipeline advances together unless a result is held back.
    assign en_s     = !ctrl_q[LAST].valid || out_ready;
    assign in_ready = en_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_ctrl_t      in_c_s;
        stage_ctrl_t      out_c_s;
        logic [W-1:0]     in_a_s;
        logic [W-1:0]     in_b_s;
        logic [W-1:0]     in_sum_s;
        logic [W-1:0]     out_sum_s;
        logic [CHUNK-1:0] s_s;
        logic             g_s;
        logic             p_s;
        logic             cm_s;
        logic             co_s;

        if (k == 0) begin : g_head
            // Operand prep: subtraction is A + ~B + 1; seed Gacc=0, Pacc=1.
            assign in_c_s   = '{valid: in_valid,
                                carry: (op_sub ? 1'b1 : c_in),
                                gacc:  1'b0,
                                pacc:  1'b1,
                                cmsb:  1'b0};
            assign in_a_s   = a;
            assign in_b_s   = op_sub ? ~b : b;
            assign in_sum_s = '0;
        end else begin : g_body
            assign in_c_s   = ctrl_q[k-1];
            assign in_a_s   = a_q[k-1];
            assign in_b_s   = b_q[k-1];
            assign in_sum_s = sum_q[k-1];
        end

        cla_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a_i     (in_a_s[k*CHUNK +: CHUNK]),
            .b_i     (in_b_s[k*CHUNK +: CHUNK]),
            .cin_i   (in_c_s.carry),
            .s_o     (s_s),
            .g_o     (g_s),
            .p_o     (p_s),
            .c_msb_o (cm_s),
            .cout_o  (co_s)
        );

        // Merge this chunk into the running record: new carry, G/P fold, sum slice.
        always_comb begin
            out_c_s       = in_c_s;
            out_c_s.carry = co_s;
            out_c_s.gacc  = g_s | (p_s & in_c_s.gacc);
            out_c_s.pacc  = p_s & in_c_s.pacc;
            out_c_s.cmsb  = cm_s;
            out_sum_s     = in_sum_s;
            out_sum_s[k*CHUNK +: CHUNK] = s_s;
        end

        assign ctrl_d[k] = out_c_s;
        assign a_d[k]    = in_a_s;
        assign b_d[k]    = in_b_s;
        assign sum_d[k]  = out_sum_s;
    end

    // Final-stage overflow detection and optional saturation of the result.
    always_comb begin
        ovf_s     = ctrl_d[LAST].cmsb ^ ctrl_d[LAST].carry;
        sum_fin_s = sum_d[LAST];
`ifdef CLA_SAT_EN
        if (ovf_s) begin
            if (!a_d[LAST][W-1] && !b_d[LAST][W-1]) begin
                sum_fin_s = {1'b0, {(W-1){1'b1}}};
            end else begin
                sum_fin_s = {1'b1, {(W-1){1'b0}}};
            end
        end else begin
            sum_fin_s = sum_d[LAST];
        end
`endif
    end

    // Stage and result registers; everything freezes while a result is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                sum_q[k]  <= '0;
            end
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
            res_g_q    <= 1'b0;
            res_p_q    <= 1'b0;
        end else if (en_s) begin
            for (int k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= ctrl_d[k];
                a_q[k]    <= a_d[k];
                b_q[k]    <= b_d[k];
                sum_q[k]  <= sum_d[k];
            end
            if (ctrl_d[LAST].valid) begin
                res_sum_q  <= sum_fin_s;
                res_cout_q <= ctrl_d[LAST].carry;
                res_ovf_q  <= ovf_s;
                res_g_q    <= ctrl_d[LAST].gacc;
                res_p_q    <= ctrl_d[LAST].pacc;
            end
        end
    end

    assign out_valid = ctrl_q[LAST].valid;
    assign sum       = res_sum_q;
    assign c_out     = res_cout_q;
    assign ovf       = res_ovf_q;
    assign g_out     = res_g_q;
    assign p_out     = res_p_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (W=32, CHUNK=8): directed vector
// table, back-to-back random traffic, backpressure and mid-flight reset,
// with a reference-model scoreboard checking every result in order.
module tb_cla_pipe_adder;

    localparam int W      = 32;
    localparam int CHUNK  = 8;
    localparam int STAGES = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c_in;
    logic          op_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          c_out;
    logic          ovf;
    logic          g_out;
    logic          p_out;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        g;
        logic        p;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic [3:0]  exp_flags;   // {c_out, ovf, g_out, p_out}
    } vec_t;

    res_t exp_q[$];
    int   pop_cyc_q[$];
    int   cycle_cnt = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    res_t mon_e;

    cla_pipe_adder #(.W(W), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .g_out     (g_out),
        .p_out     (p_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt++;

    // Reference model built on plain wide arithmetic.
    function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mcin, input logic msub);
        res_t        r;
        logic [31:0] bx;
        logic        c0;
        logic [32:0] full;
        logic [32:0] nocin;
        logic [31:0] low;
        bx    = msub ? ~mb : mb;
        c0    = msub ? 1'b1 : mcin;
        full  = {1'b0, ma} + {1'b0, bx} + {32'd0, c0};
        nocin = {1'b0, ma} + {1'b0, bx};
        low   = {1'b0, ma[30:0]} + {1'b0, bx[30:0]} + {31'd0, c0};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = low[31] ^ full[32];
        r.g    = nocin[32];
        r.p    = &(ma ^ bx);
`ifdef CLA_SAT_EN
        if (r.ovf) r.sum = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: push expectation on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL sb_unexpected: got result 0x%0h, expected no result", sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_sum", {32'd0, sum}, {32'd0, mon_e.sum});
                check("sb_flags", {60'd0, c_out, ovf, g_out, p_out},
                      {60'd0, mon_e.cout, mon_e.ovf, mon_e.g, mon_e.p});
                pop_cyc_q.push_back(cycle_cnt);
            end
        end
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(a, b, c_in, op_sub));
        end
    end

    // Present one operation and hold it until it is accepted.
    task automatic push_op(input logic [31:0] ta, input logic [31:0] tbv,
                           input logic tc, input logic ts);
        bit acc;
        int guard;
        a        = ta;
        b        = tbv;
        c_in     = tc;
        op_sub   = ts;
        in_valid = 1'b1;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: in_ready got 0, expected 1 within 50 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[8];
        logic [31:0] sat_pos;
        logic [31:0] sat_neg;
        int          lat;
        int          base;
        int          guard;
        int          stale;
        logic [31:0] held_sum;
        logic [3:0]  held_flags;
        int          pops_before;

`ifdef CLA_SAT_EN
        sat_pos = 32'h7FFF_FFFF;
        sat_neg = 32'h8000_0000;
`else
        sat_pos = 32'h8000_0000;
        sat_neg = 32'h7FFF_FFFF;
`endif
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b0000};
        vecs[2] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 4'b1010};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, sat_pos,       4'b0100};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, sat_neg,       4'b1110};
        vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 4'b0000};
        vecs[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 4'b1001};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 4'b1001};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        b         = 32'd0;
        c_in      = 1'b0;
        op_sub    = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_outputs", {28'd0, sum, c_out, ovf, g_out, p_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, one at a time, with latency measurement.
        for (int i = 0; i < 8; i++) begin
            push_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(STAGES));
            check($sformatf("vec%0d_sum", i), {32'd0, sum}, {32'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d_flags", i), {60'd0, c_out, ovf, g_out, p_out},
                  {60'd0, vecs[i].exp_flags});
        end
        repeat (2) @(posedge clk);
        #1;

        // Eight back-to-back random operations at full throughput.
        base = pop_cyc_q.size();
        for (int i = 0; i < 8; i++) begin
            push_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        guard = 0;
        while (pop_cyc_q.size() < base + 8 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("tput_count", 64'(pop_cyc_q.size() - base), 64'd8);
        if (pop_cyc_q.size() >= base + 8) begin
            check("tput_span", 64'(pop_cyc_q[base+7] - pop_cyc_q[base]), 64'd7);
        end
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: fill the pipe with out_ready low, hold 3 cycles, release.
        out_ready   = 1'b0;
        pops_before = pop_cyc_q.size();
        push_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        push_op(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1);
        push_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
        push_op(32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0);
        held_sum   = sum;
        held_flags = {c_out, ovf, g_out, p_out};
        check("bp_first_sum", {32'd0, sum}, 64'h30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold", {28'd0, sum, c_out, ovf, g_out, p_out},
                  {28'd0, held_sum, held_flags});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("bp_pops", 64'(pop_cyc_q.size() - pops_before), 64'd4);
        check("bp_last_sum", {32'd0, sum}, 64'h123);

        // Reset with three operations in flight.
        push_op(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
        push_op(32'h0000_3333, 32'h0000_0001, 1'b0, 1'b1);
        push_op(32'h0000_4444, 32'h0000_4444, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_outputs", {28'd0, sum, c_out, ovf, g_out, p_out}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale_result", 64'(stale), 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
